// File: rtl/cache_meta_array_if.sv
// cache_meta_array_if: request/response bundle for the cache metadata array
interface cache_meta_array_if #(
  parameter int s_index    = 3,
  parameter int width      = 1,
  parameter int num_rports = 2
);
  logic                           flush;
  logic                           busy;
  logic                           load;
  logic [s_index-1:0]             windex;
  logic [width-1:0]               wmask;
  logic [width-1:0]               datain;
  logic [num_rports*s_index-1:0]  rindex;
  logic [num_rports*width-1:0]    dataout;
  modport master (output flush, load, windex, wmask, datain, rindex, input busy, dataout);
  modport slave  (input flush, load, windex, wmask, datain, rindex, output busy, dataout);
endinterface

// File: rtl/cache_meta_array.sv
// cache_meta_array: multi-read-port metadata array with masked writes, write forwarding and a self-timed clear
module cache_meta_array #(
  parameter int               s_index    = 3,
  parameter int               width      = 1,
  parameter int               num_rports = 2,
  parameter logic [width-1:0] CLEAR_VAL  = '0
) (
  input logic               clk,
  input logic               rst_n,
  cache_meta_array_if.slave bus
);
  localparam int num_sets = 2 ** s_index;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t             state, state_nx;
  logic [s_index-1:0] ptr, ptr_nx;
  logic [width-1:0]   mem [num_sets];
  logic [width-1:0]   wdata;
  logic               busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    if (state == CLEAR) begin
      ptr_nx   = ptr + 1'b1;
      state_nx = &ptr ? IDLE : CLEAR;
    end else if (bus.flush) begin
      state_nx = CLEAR;
      ptr_nx   = '0;
    end
  end
  assign busy     = (state == CLEAR);
  assign bus.busy = busy;
  assign wdata    = (mem[bus.windex] & ~bus.wmask) | (bus.datain & bus.wmask);
  // storage has no reset; the clear sequencer initialises it
  always_ff @(posedge clk) begin
    if (busy)
      mem[ptr] <= CLEAR_VAL;
    else if (bus.load)
      mem[bus.windex] <= wdata;
  end
  for (genvar p = 0; p < num_rports; p++) begin : g_rd
    logic [s_index-1:0] ri;
    assign ri = bus.rindex[p*s_index +: s_index];
    assign bus.dataout[p*width +: width] = busy ? CLEAR_VAL :
                                           (bus.load && ri == bus.windex) ? wdata : mem[ri];
  end
endmodule

// File: tb/tb_cache_meta_array.sv
// tb_cache_meta_array: table-driven and sequence checks of the metadata array with a scoreboard queue
module tb_cache_meta_array;
  localparam logic [7:0] CV = 8'h5A;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  cache_meta_array_if #(.s_index(3), .width(8), .num_rports(2)) bus ();
  cache_meta_array #(.s_index(3), .width(8), .num_rports(2), .CLEAR_VAL(CV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  typedef struct packed {
    logic       load;
    logic [2:0] widx;
    logic [7:0] mask;
    logic [7:0] din;
    logic [2:0] r0;
    logic [2:0] r1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;
  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       b;
  } exp_t;
  vec_t vecs [12];
  exp_t sb [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic ld, input logic [2:0] wi, input logic [7:0] m, input logic [7:0] d,
                       input logic [2:0] r0, input logic [2:0] r1);
    bus.load   = ld;
    bus.windex = wi;
    bus.wmask  = m;
    bus.datain = d;
    bus.rindex = {r1, r0};
  endtask
  task automatic count_busy(input bit loads, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      chk("busy_dout0", {24'h0, bus.dataout[7:0]}, {24'h0, CV});
      chk("busy_dout1", {24'h0, bus.dataout[15:8]}, {24'h0, CV});
      @(posedge clk);
      #1;
      drive(loads, 3'd0, 8'hFF, 8'($urandom), 3'($urandom), 3'($urandom));
      bus.flush = loads && (n == 3);
    end
    bus.load  = 1'b0;
    bus.flush = 1'b0;
  endtask
  initial begin
    int   n;
    exp_t e;
    vecs[0]  = '{1'b1, 3'd5, 8'hFF, 8'h01, 3'd5, 3'd2, 8'h01, 8'h5A};
    vecs[1]  = '{1'b0, 3'd0, 8'hFF, 8'hEE, 3'd2, 3'd5, 8'h5A, 8'h01};
    vecs[2]  = '{1'b1, 3'd3, 8'hFF, 8'hA5, 3'd3, 3'd3, 8'hA5, 8'hA5};
    vecs[3]  = '{1'b1, 3'd3, 8'h0F, 8'h3C, 3'd3, 3'd5, 8'hAC, 8'h01};
    vecs[4]  = '{1'b0, 3'd3, 8'hFF, 8'h00, 3'd3, 3'd3, 8'hAC, 8'hAC};
    vecs[5]  = '{1'b1, 3'd7, 8'h00, 8'hFF, 3'd7, 3'd7, 8'h5A, 8'h5A};
    vecs[6]  = '{1'b0, 3'd7, 8'h00, 8'hFF, 3'd7, 3'd0, 8'h5A, 8'h5A};
    vecs[7]  = '{1'b1, 3'd0, 8'hF0, 8'h12, 3'd1, 3'd0, 8'h5A, 8'h1A};
    vecs[8]  = '{1'b1, 3'd1, 8'hFF, 8'h77, 3'd0, 3'd6, 8'h1A, 8'h5A};
    vecs[9]  = '{1'b0, 3'd1, 8'hFF, 8'h00, 3'd1, 3'd0, 8'h77, 8'h1A};
    vecs[10] = '{1'b1, 3'd6, 8'h3C, 8'hFF, 3'd6, 3'd1, 8'h7E, 8'h77};
    vecs[11] = '{1'b0, 3'd6, 8'h00, 8'h00, 3'd6, 3'd5, 8'h7E, 8'h01};
    bus.flush = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0, 3'd0);
    #12;
    chk("reset_busy", {31'h0, bus.busy}, 32'h1);
    chk("reset_dout", {16'h0, bus.dataout}, {16'h0, CV, CV});
    #5 rst_n = 1'b1;
    count_busy(1'b0, n);
    chk("init_clear_len", n, 8);
    for (int i = 0; i < 8; i += 2) begin
      @(posedge clk);
      #1;
      drive(1'b0, 3'd0, 8'h00, 8'h00, 3'(i), 3'(i + 1));
      @(negedge clk);
      chk("init_read0", {24'h0, bus.dataout[7:0]}, {24'h0, CV});
      chk("init_read1", {24'h0, bus.dataout[15:8]}, {24'h0, CV});
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].load, vecs[i].widx, vecs[i].mask, vecs[i].din, vecs[i].r0, vecs[i].r1);
      sb.push_back('{vecs[i].e0, vecs[i].e1, 1'b0});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d_dout0", i), {24'h0, bus.dataout[7:0]}, {24'h0, e.d0});
      chk($sformatf("vec%0d_dout1", i), {24'h0, bus.dataout[15:8]}, {24'h0, e.d1});
      chk($sformatf("vec%0d_busy", i), {31'h0, bus.busy}, {31'h0, e.b});
    end
    @(posedge clk);
    #1;
    drive(1'b1, 3'd1, 8'hFF, 8'h33, 3'd1, 3'd2);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_fwd", {24'h0, bus.dataout[7:0]}, 32'h33);
    chk("flush_busy0", {31'h0, bus.busy}, 32'h0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    drive(1'b1, 3'd0, 8'hFF, 8'hC3, 3'd0, 3'd1);
    count_busy(1'b1, n);
    chk("flush_clear_len", n, 8);
    @(posedge clk);
    #1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd1, 3'd0);
    @(negedge clk);
    chk("flush_entry1", {24'h0, bus.dataout[7:0]}, {24'h0, CV});
    chk("flush_entry0", {24'h0, bus.dataout[15:8]}, {24'h0, CV});
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("midrst_busy", {31'h0, bus.busy}, 32'h1);
    rst_n = 1'b1;
    count_busy(1'b0, n);
    chk("midrst_clear_len", n, 8);
    @(posedge clk);
    #1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd5, 3'd3);
    @(negedge clk);
    chk("post_read5", {24'h0, bus.dataout[7:0]}, {24'h0, CV});
    chk("post_read3", {24'h0, bus.dataout[15:8]}, {24'h0, CV});
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
